// File: rtl/bkm_req_ctrl.sv
// Request/response sequencer around a BKM core: accepts one operand set,
// pulses the core, waits for completion or timeout, then holds the result.
module bkm_req_ctrl #(
    parameter int unsigned W       = 64,
    parameter int unsigned N       = 64,
    parameter int unsigned LOG2N   = 6,
    parameter int unsigned TIMEOUT = 2 * N,
    parameter int unsigned FSIZE   = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             srst,
    input  logic             enable,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_mode,
    input  logic [1:0]       req_format,
    input  logic [W-1:0]     req_E_x,
    input  logic [W-1:0]     req_E_y,
    input  logic [W-1:0]     req_L_x,
    input  logic [W-1:0]     req_L_y,
    output logic             core_start,
    output logic             core_mode,
    output logic [1:0]       core_format,
    output logic [W-1:0]     core_E_x,
    output logic [W-1:0]     core_E_y,
    output logic [W-1:0]     core_L_x,
    output logic [W-1:0]     core_L_y,
    input  logic [W-1:0]     core_X,
    input  logic [W-1:0]     core_Y,
    input  logic [FSIZE-1:0] core_flags,
    input  logic             core_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_x,
    output logic [W-1:0]     rsp_y,
    output logic [FSIZE-1:0] rsp_flags,
    output logic             rsp_timeout,
    output logic             busy
);

    localparam int unsigned TW = LOG2N + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [TW-1:0]     r_timer, w_timer_nxt;
    logic              r_mode, w_mode_nxt;
    logic [1:0]        r_format, w_format_nxt;
    logic [W-1:0]      r_ex, r_ey, r_lx, r_ly;
    logic [W-1:0]      w_ex_nxt, w_ey_nxt, w_lx_nxt, w_ly_nxt;
    logic [W-1:0]      r_rsp_x, r_rsp_y, w_rsp_x_nxt, w_rsp_y_nxt;
    logic [FSIZE-1:0]  r_rsp_flags, w_rsp_flags_nxt;
    logic              r_rsp_timeout, w_rsp_timeout_nxt;

    // State and datapath registers; srst outranks enable.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_mode        <= 1'b0;
            r_format      <= '0;
            r_ex          <= '0;
            r_ey          <= '0;
            r_lx          <= '0;
            r_ly          <= '0;
            r_rsp_x       <= '0;
            r_rsp_y       <= '0;
            r_rsp_flags   <= '0;
            r_rsp_timeout <= 1'b0;
        end else if (srst) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_mode        <= 1'b0;
            r_format      <= '0;
            r_ex          <= '0;
            r_ey          <= '0;
            r_lx          <= '0;
            r_ly          <= '0;
            r_rsp_x       <= '0;
            r_rsp_y       <= '0;
            r_rsp_flags   <= '0;
            r_rsp_timeout <= 1'b0;
        end else if (enable) begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_mode        <= w_mode_nxt;
            r_format      <= w_format_nxt;
            r_ex          <= w_ex_nxt;
            r_ey          <= w_ey_nxt;
            r_lx          <= w_lx_nxt;
            r_ly          <= w_ly_nxt;
            r_rsp_x       <= w_rsp_x_nxt;
            r_rsp_y       <= w_rsp_y_nxt;
            r_rsp_flags   <= w_rsp_flags_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_timer_nxt       = r_timer;
        w_mode_nxt        = r_mode;
        w_format_nxt      = r_format;
        w_ex_nxt          = r_ex;
        w_ey_nxt          = r_ey;
        w_lx_nxt          = r_lx;
        w_ly_nxt          = r_ly;
        w_rsp_x_nxt       = r_rsp_x;
        w_rsp_y_nxt       = r_rsp_y;
        w_rsp_flags_nxt   = r_rsp_flags;
        w_rsp_timeout_nxt = r_rsp_timeout;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_mode_nxt   = req_mode;
                    w_format_nxt = req_format;
                    w_ex_nxt     = req_E_x;
                    w_ey_nxt     = req_E_y;
                    w_lx_nxt     = req_L_x;
                    w_ly_nxt     = req_L_y;
                    w_state_nxt  = S_START;
                end
            end
            S_START: begin
                w_timer_nxt = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_timer_nxt = r_timer + TW'(1);
                // Completion wins over a timeout landing on the same cycle.
                if (core_done) begin
                    w_rsp_x_nxt       = core_X;
                    w_rsp_y_nxt       = core_Y;
                    w_rsp_flags_nxt   = core_flags;
                    w_rsp_timeout_nxt = 1'b0;
                    w_state_nxt       = S_RESP;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_rsp_x_nxt       = '0;
                    w_rsp_y_nxt       = '0;
                    w_rsp_flags_nxt   = '0;
                    w_rsp_timeout_nxt = 1'b1;
                    w_state_nxt       = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The start pulse only counts on a cycle that actually advances the FSM.
    assign core_start  = (r_state == S_START) && enable && !srst;
    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = (r_state == S_RESP);
    assign busy        = (r_state != S_IDLE);
    assign core_mode   = r_mode;
    assign core_format = r_format;
    assign core_E_x    = r_ex;
    assign core_E_y    = r_ey;
    assign core_L_x    = r_lx;
    assign core_L_y    = r_ly;
    assign rsp_x       = r_rsp_x;
    assign rsp_y       = r_rsp_y;
    assign rsp_flags   = r_rsp_flags;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_bkm_req_ctrl.sv
// Directed bench for bkm_req_ctrl: vector table of full transactions plus
// hand-written reset, enable-gating and spurious-done sequences.
module tb_bkm_req_ctrl;

    localparam int unsigned W       = 64;
    localparam int unsigned FS      = 8;
    localparam int          TIMEOUT = 128;

    logic          clk = 1'b0;
    logic          arst, srst, enable;
    logic          req_valid, req_ready, req_mode;
    logic [1:0]    req_format;
    logic [W-1:0]  req_E_x, req_E_y, req_L_x, req_L_y;
    logic          core_start, core_mode;
    logic [1:0]    core_format;
    logic [W-1:0]  core_E_x, core_E_y, core_L_x, core_L_y;
    logic [W-1:0]  core_X, core_Y;
    logic [FS-1:0] core_flags;
    logic          core_done;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_x, rsp_y;
    logic [FS-1:0] rsp_flags;
    logic          rsp_timeout, busy;

    int checks = 0;
    int errors = 0;

    bkm_req_ctrl #(.W(W), .N(64), .LOG2N(6), .TIMEOUT(TIMEOUT), .FSIZE(FS)) dut (
        .clk(clk), .arst(arst), .srst(srst), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_format(req_format), .req_E_x(req_E_x), .req_E_y(req_E_y),
        .req_L_x(req_L_x), .req_L_y(req_L_y),
        .core_start(core_start), .core_mode(core_mode), .core_format(core_format),
        .core_E_x(core_E_x), .core_E_y(core_E_y), .core_L_x(core_L_x), .core_L_y(core_L_y),
        .core_X(core_X), .core_Y(core_Y), .core_flags(core_flags), .core_done(core_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_x(rsp_x), .rsp_y(rsp_y),
        .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          mode;
        logic [1:0]    fmt;
        logic [W-1:0]  ex, ey, lx, ly;
        int            d;      // WAIT cycle (timer value) carrying core_done; >=TIMEOUT means never
        logic [W-1:0]  x, y;
        logic [FS-1:0] f;
        int            bp;     // cycles of rsp_ready=0 before the handshake
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int w;
        int exp_w;
        logic [W-1:0]  ex_x, ex_y;
        logic [FS-1:0] ex_f;
        logic          ex_t;
        ex_t  = (v.d >= TIMEOUT);
        exp_w = ex_t ? TIMEOUT - 1 : v.d;
        ex_x  = ex_t ? '0 : v.x;
        ex_y  = ex_t ? '0 : v.y;
        ex_f  = ex_t ? '0 : v.f;

        req_valid = 1'b1; req_mode = v.mode; req_format = v.fmt;
        req_E_x = v.ex; req_E_y = v.ey; req_L_x = v.lx; req_L_y = v.ly;
        chk("req_ready_idle", W'(req_ready), W'(1));
        step();
        req_valid = 1'b0; req_E_x = '1; req_E_y = '1; req_L_x = '1; req_L_y = '1;
        chk("core_start_pulse", W'(core_start), W'(1));
        chk("core_mode", W'(core_mode), W'(v.mode));
        chk("core_format", W'(core_format), W'(v.fmt));
        chk("core_E_x", core_E_x, v.ex);
        chk("core_L_y", core_L_y, v.ly);
        chk("req_ready_busy", W'({req_ready, busy}), W'(2'b01));
        step();
        chk("core_start_once", W'(core_start), W'(0));

        for (w = 0; w < TIMEOUT + 4; w++) begin
            core_done = (w == v.d); core_X = v.x; core_Y = v.y; core_flags = v.f;
            step();
            core_done = 1'b0;
            if (rsp_valid) break;
        end
        chk("rsp_latency", W'(w), W'(exp_w));
        chk("core_E_y_held", core_E_y, v.ey);
        chk("rsp_x", rsp_x, ex_x);
        chk("rsp_y", rsp_y, ex_y);
        chk("rsp_flags", W'(rsp_flags), W'(ex_f));
        chk("rsp_timeout", W'(rsp_timeout), W'(ex_t));

        // Backpressure with a stray core_done that must not disturb the response.
        for (int i = 0; i < v.bp; i++) begin
            core_done = 1'b1; core_X = ~v.x; core_Y = ~v.y; core_flags = ~v.f;
            step();
            core_done = 1'b0;
            chk("bp_hold", {rsp_x[W-5:0], rsp_valid, req_ready, rsp_timeout, rsp_y[0]},
                {ex_x[W-5:0], 1'b1, 1'b0, ex_t, ex_y[0]});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("back_to_idle", W'({req_ready, rsp_valid, busy}), W'(3'b100));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        vecs[0] = '{1'b1, 2'd2, 64'h1, 64'h0, 64'h0, 64'h0, 68, 64'hAA, 64'h55, 8'h03, 10};
        vecs[1] = '{1'b0, 2'd1, 64'h1234_5678_9ABC_DEF0, 64'h0F0F, 64'hFFFF_0000_FFFF_0000,
                    64'h8000_0000_0000_0001, 0, 64'hDEAD_BEEF_0000_0001, 64'h1, 8'hA5, 0};
        vecs[2] = '{1'b1, 2'd3, 64'h7, 64'h8, 64'h9, 64'hA, 500, 64'h77, 64'h66, 8'hFF, 2};
        vecs[3] = '{1'b0, 2'd0, 64'h11, 64'h22, 64'h33, 64'h44, 127, 64'hC0FFEE, 64'hBEEF, 8'h5A, 1};
        vecs[4] = '{1'b1, 2'd1, 64'h5, 64'h6, 64'h7, 64'h8, 126, 64'h123, 64'h456, 8'h81, 0};

        arst = 1'b1; srst = 1'b0; enable = 1'b1; req_valid = 1'b0; req_mode = 1'b0;
        req_format = '0; req_E_x = '0; req_E_y = '0; req_L_x = '0; req_L_y = '0;
        core_X = '0; core_Y = '0; core_flags = '0; core_done = 1'b0; rsp_ready = 1'b0;
        #12;
        chk("reset_ctrl", W'({req_ready, busy, rsp_valid, core_start, rsp_timeout}), W'(5'b10000));
        chk("reset_data", core_E_x | rsp_x | rsp_y, '0);
        #2 arst = 1'b0;
        step();

        foreach (vecs[i]) run_txn(vecs[i]);

        // Spurious core_done in IDLE.
        core_done = 1'b1; core_X = 64'h99;
        repeat (3) step();
        core_done = 1'b0;
        chk("idle_done_ignored", W'({rsp_valid, req_ready, busy}), W'(3'b010));

        // Enable held low in START: no pulse until the first enabled cycle.
        req_valid = 1'b1; req_E_x = 64'h3C;
        step();
        req_valid = 1'b0;
        enable = 1'b0;
        #1 chk("en0_no_start", W'(core_start), W'(0));
        repeat (3) begin
            step();
            chk("en0_hold", W'({core_start, busy}), W'(2'b01));
        end
        enable = 1'b1;
        #1 chk("en1_start", W'(core_start), W'(1));
        step();
        chk("en1_start_once", W'(core_start), W'(0));
        core_done = 1'b1; core_X = 64'h42;
        step();
        core_done = 1'b0;
        chk("en_rsp", {rsp_x[W-2:0], rsp_valid}, {63'h42, 1'b1});
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Asynchronous reset during WAIT aborts the operation.
        req_valid = 1'b1; req_E_x = 64'h5;
        step();
        req_valid = 1'b0;
        repeat (6) step();
        #2 arst = 1'b1;
        #1 chk("arst_wait", W'({busy, req_ready, rsp_valid}), W'(3'b010));
        chk("arst_data", core_E_x, '0);
        #2 arst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < TIMEOUT + 12; i++) begin
            step();
            if (rsp_valid || busy) seen = 1'b1;
        end
        chk("no_rsp_after_arst", W'(seen), W'(0));

        // Synchronous reset wins over enable=0.
        req_valid = 1'b1; req_E_x = 64'h6;
        step();
        req_valid = 1'b0;
        step();
        enable = 1'b0; srst = 1'b1;
        step();
        srst = 1'b0; enable = 1'b1;
        chk("srst_over_enable", W'({busy, req_ready}), W'(2'b01));
        chk("srst_data", core_E_x, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bkm_req_ctrl.md
BKM_REQ_CTRL -- requirements
Module: bkm_req_ctrl

Interface
REQ-001 The block SHALL have these parameters: W, default 64, operand/result width; N, default 64, BKM iteration count; LOG2N, default 6, log2(N); TIMEOUT, default 2*N, maximum cycles waited for core_done.
REQ-002 The block SHALL have these ports, one clock and one reset, with reset asynchronous and active-high:
- clk  in  1  clock, all logic rising-edge.
- arst  in  1  asynchronous active-high reset.
- srst  in  1  synchronous active-high reset.
- enable  in  1  clock enable.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when high with req_valid.
- req_mode  in  1  BKM mode.
- req_format  in  2  BKM format.
- req_E_x, req_E_y, req_L_x, req_L_y  in  W each  operands.
- core_start  out  1  start pulse to BKM core.
- core_mode  out  1  mode to core.
- core_format  out  2  format to core.
- core_E_x, core_E_y, core_L_x, core_L_y  out  W each  operands to core.
- core_X, core_Y  in  W each  core results.
- core_flags  in  `FSIZE  core flags (bkm_defs.vh).
- core_done  in  1  core completion pulse.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_x, rsp_y  out  W each  result.
- rsp_flags  out  `FSIZE  captured flags.
- rsp_timeout  out  1  response produced by timeout, not core_done.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 The block SHALL implement an FSM with four states: IDLE, START, WAIT, RESP.
REQ-004 The FSM SHALL advance, and all registers SHALL update, only on cycles where enable=1; with enable=0 every register holds and core_start is 0.
REQ-005 In IDLE, req_ready SHALL be 1; req_ready SHALL be 0 in every other state.
REQ-006 On req_valid=1 and req_ready=1, the block SHALL capture mode, format and the four operands into core_* registers and go to START.
REQ-007 In START, core_start SHALL be 1 for exactly one enabled cycle, and the FSM SHALL go to WAIT with the timer cleared to 0.
REQ-008 core_mode, core_format and core_E_x/E_y/L_x/L_y SHALL hold stable from START until the FSM leaves WAIT.
REQ-009 In WAIT, the timer (width LOG2N+2) SHALL increment each enabled cycle.
REQ-010 In WAIT, when core_done=1, the block SHALL capture core_X, core_Y and core_flags into rsp_x, rsp_y and rsp_flags, clear rsp_timeout, and go to RESP.
REQ-011 In WAIT, when the timer reaches TIMEOUT-1 with core_done=0, the block SHALL set rsp_x, rsp_y and rsp_flags to 0, set rsp_timeout=1, and go to RESP.
REQ-012 If core_done=1 on the timeout cycle, done SHALL take precedence.
REQ-013 core_done SHALL be ignored in IDLE, START and RESP.
REQ-014 In RESP, rsp_valid SHALL be 1, and rsp_x, rsp_y, rsp_flags and rsp_timeout SHALL be stable until rsp_ready=1.
REQ-015 On the rsp_ready=1 handshake, the FSM SHALL go to IDLE; req_ready is 1 on the following cycle, with no same-cycle request bypass.
REQ-016 Request-to-response latency with immediate core_done and rsp_ready SHALL be: accept (cycle 0), core_start (cycle 1), done observed at cycle k, rsp_valid at k+1.

Reset
REQ-017 On arst=1, asynchronously, or srst=1 at a clock edge, the block SHALL force state IDLE and timer 0.
REQ-018 On reset, core_start, rsp_valid, rsp_timeout and busy SHALL be 0, req_ready SHALL be 1, and all data outputs SHALL be 0.
REQ-019 srst SHALL take priority over enable.
REQ-020 Reset in any state SHALL abort the operation and discard any pending response.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Basic: request mode=1, format=2, E_x=0x1 -> core_start one pulse at cycle 1; core_done at cycle 70 with X=0xAA, Y=0x55 -> rsp_valid at cycle 71 with rsp_x=0xAA, rsp_y=0x55, rsp_timeout=0.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_* stable, req_ready=0 throughout; after rsp_ready=1 -> IDLE next cycle.
- Timeout: no core_done -> rsp_valid after TIMEOUT (128) WAIT cycles with rsp_timeout=1 and rsp_x=rsp_y=0.
- Enable gating: enable=0 during START -> core_start stays 0; core_start fires on the first enabled cycle.
- Spurious core_done in IDLE -> no rsp_valid; arst during WAIT -> IDLE, busy=0, and no response after release.
- Done on the timeout cycle -> rsp_timeout=0 and core results captured.
